// File: rtl/fp_align_shifter_if.sv
// fp_align_shifter_if -- operand/result bus of the mantissa alignment stage.
//
// Signals:
//   in_valid / in_ready      operand pair handshake
//   exp_a, man_a             operand A (biased exponent, mantissa with hidden bit)
//   exp_b, man_b             operand B
//   sub                      effective-subtract flag, carried alongside the pair
//   out_valid / out_ready    aligned result handshake
//   out_exp                  larger exponent
//   out_man_big              mantissa of the larger-magnitude operand
//   out_man_small            aligned smaller mantissa
//   out_grs                  {guard, round, sticky}
//   out_swap                 1 when B was the larger operand
//   out_sub                  registered copy of sub
//
// Modports:
//   slave  -- the alignment stage (consumes operands, produces results)
//   master -- the surrounding logic (produces operands, consumes results)
interface fp_align_shifter_if #(
  parameter int MAN_W = 16,
  parameter int EXP_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_a;
  logic [MAN_W-1:0] man_a;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] man_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_man_big;
  logic [MAN_W-1:0] out_man_small;
  logic [2:0]       out_grs;
  logic             out_swap;
  logic             out_sub;

  modport slave (
    input  in_valid, exp_a, man_a, exp_b, man_b, sub, out_ready,
    output in_ready, out_valid, out_exp, out_man_big, out_man_small,
           out_grs, out_swap, out_sub
  );

  modport master (
    output in_valid, exp_a, man_a, exp_b, man_b, sub, out_ready,
    input  in_ready, out_valid, out_exp, out_man_big, out_man_small,
           out_grs, out_swap, out_sub
  );
endinterface

// File: rtl/fp_align_shifter.sv
// fp_align_shifter -- mantissa alignment stage ahead of the mantissa adder.
//
// Stage 1 orders the two operands by magnitude and registers the larger
// exponent, both mantissas and the exponent distance. Stage 2 right-shifts
// the smaller mantissa by that distance and forms guard/round/sticky.
// Two-deep valid/ready pipeline, one pair per cycle, 2-cycle latency.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    operand/result bus (slave view), see fp_align_shifter_if
module fp_align_shifter #(
  parameter int MAN_W = 16,
  parameter int EXP_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_align_shifter_if.slave    bus
);

  localparam int EXT_W = MAN_W + 2;
  // Largest shift that still leaves a bit inside the extended mantissa.
  localparam int MAX_SH = MAN_W + 1;

  // ---------------------------------------------------------------- handshake
  logic s1_valid;
  logic s2_valid;
  logic s2_take;
  logic s1_take;

  assign s2_take = !s2_valid || bus.out_ready;
  assign s1_take = !s1_valid || s2_take;

  assign bus.in_ready  = s1_take;
  assign bus.out_valid = s2_valid;

  // ---------------------------------------------------------- stage 1 (comb)
  logic [EXP_W:0]   diff;
  logic [EXP_W:0]   diff_neg;
  logic             swap_c;
  logic [EXP_W-1:0] d_c;

  assign diff     = {1'b0, bus.exp_a} - {1'b0, bus.exp_b};
  assign diff_neg = -diff;
  assign swap_c   = (bus.exp_b > bus.exp_a) ||
                    ((bus.exp_a == bus.exp_b) && (bus.man_b > bus.man_a));
  // diff MSB set means exp_b > exp_a, so the magnitude is the negation.
  assign d_c      = diff[EXP_W] ? diff_neg[EXP_W-1:0] : diff[EXP_W-1:0];

  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W-1:0] s1_big;
  logic [MAN_W-1:0] s1_small;
  logic [EXP_W-1:0] s1_d;
  logic             s1_swap;
  logic             s1_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_exp   <= '0;
      s1_big   <= '0;
      s1_small <= '0;
      s1_d     <= '0;
      s1_swap  <= 1'b0;
      s1_sub   <= 1'b0;
    end else if (s1_take) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_exp   <= swap_c ? bus.exp_b : bus.exp_a;
        s1_big   <= swap_c ? bus.man_b : bus.man_a;
        s1_small <= swap_c ? bus.man_a : bus.man_b;
        s1_d     <= d_c;
        s1_swap  <= swap_c;
        s1_sub   <= bus.sub;
      end
    end
  end

  // ---------------------------------------------------------- stage 2 (comb)
  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] lost_mask;
  logic [EXT_W-1:0] sh;
  logic             lost;

  assign ext = {s1_small, 2'b00};

  always_comb begin
    sh        = '0;
    lost      = 1'b0;
    lost_mask = '0;
    if (32'(s1_d) <= MAX_SH) begin
      sh        = ext >> s1_d;
      lost_mask = (EXT_W'(1) << s1_d) - EXT_W'(1);
      lost      = |(ext & lost_mask);
    end else begin
      // Everything shifted out: only the sticky bit survives.
      sh   = '0;
      lost = |s1_small;
    end
  end

  logic [EXP_W-1:0] s2_exp;
  logic [MAN_W-1:0] s2_big;
  logic [MAN_W-1:0] s2_small;
  logic [2:0]       s2_grs;
  logic             s2_swap;
  logic             s2_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_exp   <= '0;
      s2_big   <= '0;
      s2_small <= '0;
      s2_grs   <= '0;
      s2_swap  <= 1'b0;
      s2_sub   <= 1'b0;
    end else if (s2_take) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_exp   <= s1_exp;
        s2_big   <= s1_big;
        s2_small <= sh[EXT_W-1:2];
        s2_grs   <= {sh[1], sh[0], lost};
        s2_swap  <= s1_swap;
        s2_sub   <= s1_sub;
      end
    end
  end

  assign bus.out_exp       = s2_exp;
  assign bus.out_man_big   = s2_big;
  assign bus.out_man_small = s2_small;
  assign bus.out_grs       = s2_grs;
  assign bus.out_swap      = s2_swap;
  assign bus.out_sub       = s2_sub;

endmodule

// File: doc/fp_align_shifter.md
Name: fp_align_shifter

Overview:
- Mantissa alignment stage directly upstream of the 16-bit carry-select mantissa adder in the FPU add path.
- Takes two unpacked operands (exponent + mantissa with hidden bit) and orders them by magnitude.
- Right-shifts the smaller mantissa by the exponent difference and produces guard/round/sticky bits.
- Two-stage valid/ready pipeline; outputs feed the adder's A/B inputs and the downstream rounding logic.

Parameters:
- MAN_W, 16, mantissa width including hidden bit; equals adder width.
- EXP_W, 5, exponent width (unsigned, biased).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input operand pair valid
- in_ready  output  1  stage can accept the pair this cycle
- exp_a  input  EXP_W  operand A exponent
- man_a  input  MAN_W  operand A mantissa
- exp_b  input  EXP_W  operand B exponent
- man_b  input  MAN_W  operand B mantissa
- sub  input  1  effective-subtract flag, passed through
- out_valid  output  1  aligned result valid
- out_ready  input  1  downstream (adder stage) accepts result
- out_exp  output  EXP_W  larger exponent
- out_man_big  output  MAN_W  mantissa of the larger-magnitude operand
- out_man_small  output  MAN_W  aligned (shifted) smaller mantissa
- out_grs  output  3  {guard, round, sticky} of the shifted mantissa
- out_swap  output  1  1 when B was the larger operand
- out_sub  output  1  registered copy of sub

Behaviour:
- Reset (async, rst_n=0): both stage valid flags cleared; all output registers 0; in_ready=1 from the first edge after release.
- Handshake: transfer on valid&&ready at the clock edge. Stage k advances when it is empty, or when its contents move on in the same cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - out_valid = s2_valid.
- Latency 2 cycles from input transfer to out_valid with out_ready held high; throughput 1 pair per cycle.
- Stall: while out_valid && !out_ready, every output holds stable. Stage 1 still fills if empty. At most 2 pairs are in flight; order is preserved.
- Simultaneous output consume and input accept: both occur in the same edge, with no bubble.
- Stage 1 (compare/swap):
  - diff = {1'b0,exp_a} - {1'b0,exp_b}, computed in EXP_W+1 bits.
  - swap = (exp_b > exp_a) || (exp_a == exp_b && man_b > man_a).
  - Register big/small mantissas, exp = max, d = |diff| (EXP_W bits), swap, sub.
- Stage 2 (shift):
  - ext = {small, 2'b00} (MAN_W+2 bits).
  - If d <= MAN_W+1: sh = ext >> d, and lost = OR of the d LSBs of ext.
  - If d > MAN_W+1 (saturation): sh = 0, and lost = |small.
  - out_man_small = sh[MAN_W+1:2]; guard = sh[1]; round = sh[0]; sticky = lost.
  - d=0: small passes unchanged, grs=000.
- No special handling of zero, denormal or infinity; those are resolved upstream. Equal operands give swap=0.
- Reset asserted mid-operation: in-flight pairs are discarded and out_valid drops asynchronously, with no partial output.

Test Plan:
1. exp_a=10, man_a=0x8000, exp_b=8, man_b=0xC000, out_ready=1 -> after 2 cycles: out_exp=10, big=0x8000, small=0x3000, grs=000, swap=0.
2. exp_a=5, man_a=0x8001, exp_b=9, man_b=0x9000 -> swap=1, out_exp=9, big=0x9000, small=0x0800, grs=001.
3. exp_a=25, man_a=0x8000, exp_b=5, man_b=0x0003 (d=20, saturation) -> small=0x0000, grs=001. Then exp_a=3, man_a=0x8000, exp_b=2, man_b=0x0003 (d=1) -> small=0x0001, grs=100.
4. exp_a=exp_b=7, man_a=0x9000, man_b=0xA000 -> swap=1, big=0xA000, small=0x9000, grs=000. man_a=man_b=0x9000 -> swap=0.
5. Stream 4 pairs with out_ready=0 for 3 cycles, then 1 -> in_ready=0 once 2 pairs are held; outputs stable during the stall; all 4 results emerge in order with no loss or duplication.
6. Assert rst_n=0 while out_valid=1 -> out_valid=0 and outputs 0 immediately; after release in_ready=1 and the next pair yields a correct result 2 cycles after transfer.
